rocc_cmd_arbiter: RTL and testbench

- Shares the single ROCC accelerator command/response port between NUM_REQ independent requesters, such as DPI-driven test threads or multiple host cores.
- Arbitrates the cmd channel round-robin into a registered output stage.
- Remaps each xd=1 command's rd to a free internal tag and records the original rd and requester.
- Routes ROCC responses back to the owning requester with the original rd restored.

---
 rtl/rocc_cmd_arbiter.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_rocc_cmd_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rocc_cmd_arbiter.sv
// rocc_cmd_arbiter: shares one ROCC cmd/resp port between NUM_REQ requesters.
// Cmds are arbitrated round-robin into a single registered output stage.
// The rd of each xd=1 cmd is swapped for an internal tag, and the original
// rd is restored when the matching response returns to its owner.
// Optional build macro ROCC_ARB_PERF_EN adds grant and tag-stall counters.
// Without it the perf ports are still present but tied to zero.
module rocc_cmd_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned NUM_TAGS = 8,
   parameter int unsigned XLEN     = 64
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [NUM_REQ-1:0]      req_cmd_valid,
   output logic [NUM_REQ-1:0]      req_cmd_ready,
   input  logic [7*NUM_REQ-1:0]    req_cmd_funct,
   input  logic [5*NUM_REQ-1:0]    req_cmd_rd,
   input  logic [NUM_REQ-1:0]      req_cmd_xd,
   input  logic [XLEN*NUM_REQ-1:0] req_cmd_rs1,
   input  logic [XLEN*NUM_REQ-1:0] req_cmd_rs2,
   output logic [NUM_REQ-1:0]      req_resp_valid,
   input  logic [NUM_REQ-1:0]      req_resp_ready,
   output logic [4:0]              req_resp_rd,
   output logic [XLEN-1:0]         req_resp_dat,
   output logic                    io_cmd_valid,
   input  logic                    io_cmd_ready,
   output logic [6:0]              io_cmd_bits_inst_funct,
   output logic [4:0]              io_cmd_bits_inst_rd,
   output logic                    io_cmd_bits_inst_xd,
   output logic [XLEN-1:0]         io_cmd_bits_rs1,
   output logic [XLEN-1:0]         io_cmd_bits_rs2,
   input  logic                    io_resp_valid,
   output logic                    io_resp_ready,
   input  logic [4:0]              io_resp_bits_rd,
   input  logic [XLEN-1:0]         io_resp_bits_dat,
   output logic                    err_unexpected_resp,
   output logic [32*NUM_REQ-1:0]   perf_grant_count,
   output logic [31:0]             perf_tag_stall
);

   localparam int unsigned REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned TAG_W   = 5;
   localparam int unsigned FUNCT_W = 7;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_e;

   stage_e stage_q;
   stage_e stage_d;

   logic [REQ_W-1:0]   rr_q;
   logic [NUM_TAGS-1:0] tag_vld_q;
   logic [REQ_W-1:0]   tag_req_q [NUM_TAGS];
   logic [TAG_W-1:0]   tag_rd_q  [NUM_TAGS];

   logic               tag_avail;
   logic [TAG_W-1:0]   free_tag;
   logic [NUM_REQ-1:0] eligible;
   logic               grant_vld;
   logic [REQ_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant_oh;
   logic               load_ok;
   logic               accept;
   logic               alloc;

   logic [FUNCT_W-1:0] sel_funct;
   logic [TAG_W-1:0]   sel_rd;
   logic               sel_xd;
   logic [XLEN-1:0]    sel_rs1;
   logic [XLEN-1:0]    sel_rs2;

   logic               resp_hit;
   logic [REQ_W-1:0]   resp_owner;
   logic [TAG_W-1:0]   resp_orig_rd;
   logic               resp_fire;

   // Lowest-index free tag and whether any tag is free at all
   always_comb begin
      tag_avail = 1'b0;
      free_tag  = '0;
      for (int unsigned t = 0; t < NUM_TAGS; t++) begin
         if (!tag_avail && !tag_vld_q[t]) begin
            tag_avail = 1'b1;
            free_tag  = TAG_W'(t);
         end
      end
   end

   // xd=1 requesters are only eligible while a tag can be handed out
   assign eligible = req_cmd_valid & (~req_cmd_xd | {NUM_REQ{tag_avail}});

   // Round-robin search starting at the pointer, wrapping modulo NUM_REQ
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && eligible[i] &&
                (i == ((32'(rr_q) + k) % NUM_REQ))) begin
               grant_vld = 1'b1;
               grant_idx = REQ_W'(i);
            end
         end
      end
   end

   // Payload mux for the granted requester
   always_comb begin
      sel_funct = '0;
      sel_rd    = '0;
      sel_xd    = 1'b0;
      sel_rs1   = '0;
      sel_rs2   = '0;
      grant_oh  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_vld && (grant_idx == REQ_W'(i))) begin
            grant_oh[i] = 1'b1;
            sel_funct   = req_cmd_funct[FUNCT_W*i +: FUNCT_W];
            sel_rd      = req_cmd_rd[TAG_W*i +: TAG_W];
            sel_xd      = req_cmd_xd[i];
            sel_rs1     = req_cmd_rs1[XLEN*i +: XLEN];
            sel_rs2     = req_cmd_rs2[XLEN*i +: XLEN];
         end
      end
   end

   // Output stage state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stage_q <= ST_EMPTY;
      end else begin
         stage_q <= stage_d;
      end
   end

   // Output stage next state: load when empty or when draining this cycle
   always_comb begin
      stage_d = stage_q;
      load_ok = 1'b0;
      case (stage_q)
         ST_EMPTY: begin
            load_ok = 1'b1;
            if (grant_vld) begin
               stage_d = ST_FULL;
            end
         end
         ST_FULL: begin
            load_ok = io_cmd_ready;
            if (io_cmd_ready && !grant_vld) begin
               stage_d = ST_EMPTY;
            end
         end
         default: begin
            stage_d = ST_EMPTY;
         end
      endcase
   end

   assign accept        = grant_vld & load_ok & reset_n;
   assign alloc         = accept & sel_xd;
   assign req_cmd_ready = accept ? grant_oh : '0;
   assign io_cmd_valid  = (stage_q == ST_FULL);

   // Output register: captures the granted cmd, rd replaced by tag for xd=1
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         io_cmd_bits_inst_funct <= '0;
         io_cmd_bits_inst_rd    <= '0;
         io_cmd_bits_inst_xd    <= 1'b0;
         io_cmd_bits_rs1        <= '0;
         io_cmd_bits_rs2        <= '0;
      end else if (accept) begin
         io_cmd_bits_inst_funct <= sel_funct;
         io_cmd_bits_inst_rd    <= sel_xd ? free_tag : sel_rd;
         io_cmd_bits_inst_xd    <= sel_xd;
         io_cmd_bits_rs1        <= sel_rs1;
         io_cmd_bits_rs2        <= sel_rs2;
      end
   end

   // Round-robin pointer moves past each granted requester
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rr_q <= '0;
      end else if (accept) begin
         rr_q <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
   end

   // Tag lookup for the returning response (out-of-range tags never hit)
   always_comb begin
      resp_hit     = 1'b0;
      resp_owner   = '0;
      resp_orig_rd = '0;
      for (int unsigned t = 0; t < NUM_TAGS; t++) begin
         if ((io_resp_bits_rd == TAG_W'(t)) && tag_vld_q[t]) begin
            resp_hit     = 1'b1;
            resp_owner   = tag_req_q[t];
            resp_orig_rd = tag_rd_q[t];
         end
      end
   end

   // Response routing to the owning requester; stray responses are sunk
   always_comb begin
      req_resp_valid = '0;
      io_resp_ready  = 1'b1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (resp_hit && (resp_owner == REQ_W'(i))) begin
            req_resp_valid[i] = io_resp_valid;
            io_resp_ready     = req_resp_ready[i];
         end
      end
      req_resp_rd  = resp_hit ? resp_orig_rd : '0;
      req_resp_dat = io_resp_bits_dat;
   end

   assign resp_fire = io_resp_valid & io_resp_ready & resp_hit;

   // Tag table: free on response handshake, allocate on xd=1 grant
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tag_vld_q <= '0;
         for (int unsigned t = 0; t < NUM_TAGS; t++) begin
            tag_req_q[t] <= '0;
            tag_rd_q[t]  <= '0;
         end
      end else begin
         for (int unsigned t = 0; t < NUM_TAGS; t++) begin
            if (resp_fire && (io_resp_bits_rd == TAG_W'(t))) begin
               tag_vld_q[t] <= 1'b0;
            end
            if (alloc && (free_tag == TAG_W'(t))) begin
               tag_vld_q[t] <= 1'b1;
               tag_req_q[t] <= grant_idx;
               tag_rd_q[t]  <= sel_rd;
            end
         end
      end
   end

   // Sticky flag for responses carrying an unallocated tag
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_unexpected_resp <= 1'b0;
      end else if (io_resp_valid && !resp_hit) begin
         err_unexpected_resp <= 1'b1;
      end
   end

`ifdef ROCC_ARB_PERF_EN
   logic [31:0] grant_cnt_q [NUM_REQ];
   logic [31:0] stall_cnt_q;
   logic        tag_stall;

   assign tag_stall = (|(req_cmd_valid & req_cmd_xd)) & ~tag_avail;

   // Per-requester saturating grant counters
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (accept && (grant_idx == REQ_W'(i)) && (grant_cnt_q[i] != '1)) begin
               grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
            end
         end
      end
   end

   // Saturating count of cycles where an xd=1 requester waits for a tag
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
      end else if (tag_stall && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   // Flatten counters onto the perf port
   always_comb begin
      perf_grant_count = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         perf_grant_count[32*i +: 32] = grant_cnt_q[i];
      end
   end

   assign perf_tag_stall = stall_cnt_q;
`else
   assign perf_grant_count = '0;
   assign perf_tag_stall   = '0;
`endif

endmodule

// File: tb/tb_rocc_cmd_arbiter.sv
// Self-checking bench for rocc_cmd_arbiter (4 requesters, 4 tags).
// Expected io_cmd beats are queued as stimulus is driven and checked in order
// as the arbiter presents them; scenario tasks check everything else inline.
module tb_rocc_cmd_arbiter;

   typedef struct packed {
      logic [6:0]  funct;
      logic [4:0]  rd;
      logic        xd;
      logic [63:0] rs1;
      logic [63:0] rs2;
   } cmd_t;

   logic         clock;
   logic         reset_n;
   logic [3:0]   req_cmd_valid;
   logic [3:0]   req_cmd_ready;
   logic [3:0]   req_cmd_xd;
   logic [6:0]   f_a   [4];
   logic [4:0]   rd_a  [4];
   logic [63:0]  rs1_a [4];
   logic [63:0]  rs2_a [4];
   logic [27:0]  req_cmd_funct;
   logic [19:0]  req_cmd_rd;
   logic [255:0] req_cmd_rs1;
   logic [255:0] req_cmd_rs2;
   logic [3:0]   req_resp_valid;
   logic [3:0]   req_resp_ready;
   logic [4:0]   req_resp_rd;
   logic [63:0]  req_resp_dat;
   logic         io_cmd_valid;
   logic         io_cmd_ready;
   logic [6:0]   io_cmd_bits_inst_funct;
   logic [4:0]   io_cmd_bits_inst_rd;
   logic         io_cmd_bits_inst_xd;
   logic [63:0]  io_cmd_bits_rs1;
   logic [63:0]  io_cmd_bits_rs2;
   logic         io_resp_valid;
   logic         io_resp_ready;
   logic [4:0]   io_resp_bits_rd;
   logic [63:0]  io_resp_bits_dat;
   logic         err_unexpected_resp;
   logic [127:0] perf_grant_count;
   logic [31:0]  perf_tag_stall;

   cmd_t       io_cmd_now;
   cmd_t       mon_e;
   cmd_t       exp_q [$];
   logic [1:0] grant_q [$];
   int         checks;
   int         errors;

   assign req_cmd_funct = {f_a[3], f_a[2], f_a[1], f_a[0]};
   assign req_cmd_rd    = {rd_a[3], rd_a[2], rd_a[1], rd_a[0]};
   assign req_cmd_rs1   = {rs1_a[3], rs1_a[2], rs1_a[1], rs1_a[0]};
   assign req_cmd_rs2   = {rs2_a[3], rs2_a[2], rs2_a[1], rs2_a[0]};
   assign io_cmd_now    = {io_cmd_bits_inst_funct, io_cmd_bits_inst_rd,
                           io_cmd_bits_inst_xd, io_cmd_bits_rs1, io_cmd_bits_rs2};

   rocc_cmd_arbiter #(.NUM_REQ(4), .NUM_TAGS(4), .XLEN(64)) dut (
      .clock                  (clock),
      .reset_n                (reset_n),
      .req_cmd_valid          (req_cmd_valid),
      .req_cmd_ready          (req_cmd_ready),
      .req_cmd_funct          (req_cmd_funct),
      .req_cmd_rd             (req_cmd_rd),
      .req_cmd_xd             (req_cmd_xd),
      .req_cmd_rs1            (req_cmd_rs1),
      .req_cmd_rs2            (req_cmd_rs2),
      .req_resp_valid         (req_resp_valid),
      .req_resp_ready         (req_resp_ready),
      .req_resp_rd            (req_resp_rd),
      .req_resp_dat           (req_resp_dat),
      .io_cmd_valid           (io_cmd_valid),
      .io_cmd_ready           (io_cmd_ready),
      .io_cmd_bits_inst_funct (io_cmd_bits_inst_funct),
      .io_cmd_bits_inst_rd    (io_cmd_bits_inst_rd),
      .io_cmd_bits_inst_xd    (io_cmd_bits_inst_xd),
      .io_cmd_bits_rs1        (io_cmd_bits_rs1),
      .io_cmd_bits_rs2        (io_cmd_bits_rs2),
      .io_resp_valid          (io_resp_valid),
      .io_resp_ready          (io_resp_ready),
      .io_resp_bits_rd        (io_resp_bits_rd),
      .io_resp_bits_dat       (io_resp_bits_dat),
      .err_unexpected_resp    (err_unexpected_resp),
      .perf_grant_count       (perf_grant_count),
      .perf_tag_stall         (perf_tag_stall)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Scoreboard: each io_cmd handshake must match the oldest expected cmd
   always @(negedge clock) begin
      if (reset_n && io_cmd_valid && io_cmd_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL io_cmd_unexpected got %h", io_cmd_now);
         end else begin
            mon_e = exp_q.pop_front();
            if (io_cmd_now !== mon_e) begin
               errors++;
               $display("FAIL io_cmd got %h exp %h", io_cmd_now, mon_e);
            end
         end
      end
      if (reset_n) begin
         for (int i = 0; i < 4; i++) begin
            if (req_cmd_valid[i] && req_cmd_ready[i]) grant_q.push_back(2'(i));
         end
      end
   end

   task automatic set_req(input logic [1:0] i, input logic [6:0] f, input logic [4:0] rd,
                          input logic xd, input logic [63:0] a, input logic [63:0] b);
      f_a[i]        = f;
      rd_a[i]       = rd;
      req_cmd_xd[i] = xd;
      rs1_a[i]      = a;
      rs2_a[i]      = b;
   endtask

   // Single cmd from requester i; bounded wait for its handshake
   task automatic send(input logic [1:0] i, input logic [6:0] f, input logic [4:0] rd,
                       input logic xd, input logic [63:0] a, input logic [63:0] b);
      @(posedge clock); #1;
      set_req(i, f, rd, xd, a, b);
      req_cmd_valid[i] = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         if (req_cmd_ready[i]) break;
      end
      @(posedge clock); #1;
      req_cmd_valid[i] = 1'b0;
   endtask

   task automatic test_reset;
      req_cmd_valid = 4'hF;
      repeat (2) @(negedge clock);
      checks++;
      if (io_cmd_valid !== 1'b0) begin
         errors++; $display("FAIL rst_valid got %b exp 0", io_cmd_valid);
      end
      checks++;
      if (io_cmd_now !== '0) begin
         errors++; $display("FAIL rst_bits got %h exp 0", io_cmd_now);
      end
      checks++;
      if (req_cmd_ready !== 4'b0000) begin
         errors++; $display("FAIL rst_ready got %b exp 0000", req_cmd_ready);
      end
      checks++;
      if (err_unexpected_resp !== 1'b0) begin
         errors++; $display("FAIL rst_err got %b exp 0", err_unexpected_resp);
      end
      checks++;
      if (perf_grant_count !== '0 || perf_tag_stall !== '0) begin
         errors++; $display("FAIL rst_perf got %h/%h exp 0", perf_grant_count, perf_tag_stall);
      end
      @(posedge clock); #1;
      req_cmd_valid = 4'h0;
      reset_n = 1'b1;
   endtask

   task automatic test_round_robin;
      for (int i = 0; i < 4; i++) set_req(2'(i), 7'(16 + i), 5'(i), 1'b0, 64'(100 + i), 64'(200 + i));
      for (int k = 0; k < 8; k++)
         exp_q.push_back({7'(16 + k % 4), 5'(k % 4), 1'b0, 64'(100 + k % 4), 64'(200 + k % 4)});
      grant_q.delete();
      @(posedge clock); #1;
      req_cmd_valid = 4'hF;
      @(negedge clock);
      checks++;
      if (io_cmd_valid !== 1'b0 || req_cmd_ready !== 4'b0001) begin
         errors++; $display("FAIL rr_first got v=%b rdy=%b exp v=0 rdy=0001", io_cmd_valid, req_cmd_ready);
      end
      @(negedge clock);
      checks++;
      if (io_cmd_valid !== 1'b1 || io_cmd_bits_inst_funct !== 7'h10 || req_cmd_ready !== 4'b0010) begin
         errors++;
         $display("FAIL rr_latency got v=%b f=%h rdy=%b exp v=1 f=10 rdy=0010",
                  io_cmd_valid, io_cmd_bits_inst_funct, req_cmd_ready);
      end
      repeat (6) @(negedge clock);
      @(posedge clock); #1;
      req_cmd_valid = 4'h0;
      repeat (3) @(negedge clock);
      checks++;
      if (grant_q.size() != 8) begin
         errors++; $display("FAIL rr_count got %0d exp 8", grant_q.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (grant_q[k] !== 2'(k % 4)) begin
               errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", k, grant_q[k], k % 4);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL rr_drain got %0d pending exp 0", exp_q.size());
      end
      grant_q.delete();
   endtask

   task automatic test_remap;
      exp_q.push_back({7'd5, 5'd0, 1'b1, 64'hA, 64'hB});
      send(2'd2, 7'd5, 5'd17, 1'b1, 64'hA, 64'hB);
      repeat (2) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL remap_cmd got %0d pending exp 0", exp_q.size());
      end
      @(posedge clock); #1;
      io_resp_valid = 1'b1; io_resp_bits_rd = 5'd0; io_resp_bits_dat = 64'h1234; req_resp_ready = 4'hF;
      @(negedge clock);
      checks++;
      if (req_resp_valid !== 4'b0100 || req_resp_rd !== 5'd17 || req_resp_dat !== 64'h1234 ||
          io_resp_ready !== 1'b1) begin
         errors++;
         $display("FAIL remap_resp got v=%b rd=%0d dat=%h rdy=%b exp v=0100 rd=17 dat=1234 rdy=1",
                  req_resp_valid, req_resp_rd, req_resp_dat, io_resp_ready);
      end
      @(posedge clock); #1;
      io_resp_valid = 1'b0;
      // Freed tag 0 is handed out again, response backpressured by owner
      exp_q.push_back({7'd6, 5'd0, 1'b1, 64'h1, 64'h2});
      send(2'd1, 7'd6, 5'd9, 1'b1, 64'h1, 64'h2);
      repeat (2) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL remap_reuse got %0d pending exp 0", exp_q.size());
      end
      @(posedge clock); #1;
      io_resp_valid = 1'b1; io_resp_bits_rd = 5'd0; io_resp_bits_dat = 64'h55; req_resp_ready = 4'b1101;
      @(negedge clock);
      checks++;
      if (req_resp_valid !== 4'b0010 || req_resp_rd !== 5'd9 || io_resp_ready !== 1'b0) begin
         errors++;
         $display("FAIL remap_bp got v=%b rd=%0d rdy=%b exp v=0010 rd=9 rdy=0",
                  req_resp_valid, req_resp_rd, io_resp_ready);
      end
      @(posedge clock); #1;
      req_resp_ready = 4'hF;
      @(negedge clock);
      checks++;
      if (io_resp_ready !== 1'b1) begin
         errors++; $display("FAIL remap_release got rdy=%b exp 1", io_resp_ready);
      end
      @(posedge clock); #1;
      io_resp_valid = 1'b0;
   endtask

   task automatic test_tag_exhaust;
      logic [4:0] tagv [4] = '{5'd0, 5'd1, 5'd3, 5'd2};
      logic [3:0] ownv [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      logic [4:0] rdv  [4] = '{5'd10, 5'd11, 5'd13, 5'd20};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({7'(32 + i), 5'(i), 1'b1, 64'(i), 64'(i + 1)});
         send(2'(i), 7'(32 + i), 5'(10 + i), 1'b1, 64'(i), 64'(i + 1));
      end
      exp_q.push_back({7'd41, 5'd3, 1'b0, 64'h7, 64'h8});
      @(posedge clock); #1;
      set_req(2'd0, 7'd40, 5'd20, 1'b1, 64'hC0, 64'hC1);
      set_req(2'd1, 7'd41, 5'd3, 1'b0, 64'h7, 64'h8);
      req_cmd_valid = 4'b0011;
      @(negedge clock);
      checks++;
      if (req_cmd_ready !== 4'b0010) begin
         errors++; $display("FAIL exhaust_skip got %b exp 0010", req_cmd_ready);
      end
      @(posedge clock); #1;
      req_cmd_valid = 4'b0001;
      repeat (3) begin
         @(negedge clock);
         checks++;
         if (req_cmd_ready !== 4'b0000) begin
            errors++; $display("FAIL exhaust_block got %b exp 0000", req_cmd_ready);
         end
      end
      exp_q.push_back({7'd40, 5'd2, 1'b1, 64'hC0, 64'hC1});
      @(posedge clock); #1;
      io_resp_valid = 1'b1; io_resp_bits_rd = 5'd2; io_resp_bits_dat = 64'hD2; req_resp_ready = 4'hF;
      @(negedge clock);
      checks++;
      if (req_resp_valid !== 4'b0100 || req_resp_rd !== 5'd12 || req_cmd_ready !== 4'b0000) begin
         errors++;
         $display("FAIL exhaust_free got v=%b rd=%0d crdy=%b exp v=0100 rd=12 crdy=0000",
                  req_resp_valid, req_resp_rd, req_cmd_ready);
      end
      @(posedge clock); #1;
      io_resp_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (req_cmd_ready !== 4'b0001) begin
         errors++; $display("FAIL exhaust_reuse got %b exp 0001", req_cmd_ready);
      end
      @(posedge clock); #1;
      req_cmd_valid = 4'b0000;
      repeat (2) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL exhaust_drain got %0d pending exp 0", exp_q.size());
      end
      for (int j = 0; j < 4; j++) begin
         @(posedge clock); #1;
         io_resp_valid = 1'b1; io_resp_bits_rd = tagv[j]; io_resp_bits_dat = 64'(j);
         @(negedge clock);
         checks++;
         if (req_resp_valid !== ownv[j] || req_resp_rd !== rdv[j]) begin
            errors++;
            $display("FAIL exhaust_route tag %0d got v=%b rd=%0d exp v=%b rd=%0d",
                     tagv[j], req_resp_valid, req_resp_rd, ownv[j], rdv[j]);
         end
         @(posedge clock); #1;
         io_resp_valid = 1'b0;
      end
   endtask

   task automatic test_backpressure;
      cmd_t hold_c = {7'h11, 5'd4, 1'b0, 64'h111, 64'h112};
      @(posedge clock); #1;
      io_cmd_ready = 1'b0;
      exp_q.push_back(hold_c);
      exp_q.push_back({7'h22, 5'd6, 1'b0, 64'h221, 64'h222});
      send(2'd3, 7'h11, 5'd4, 1'b0, 64'h111, 64'h112);
      set_req(2'd0, 7'h22, 5'd6, 1'b0, 64'h221, 64'h222);
      req_cmd_valid = 4'b0001;
      repeat (5) begin
         @(negedge clock);
         checks++;
         if (io_cmd_valid !== 1'b1 || io_cmd_now !== hold_c || req_cmd_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_hold got v=%b bits=%h rdy=%b exp v=1 bits=%h rdy=0000",
                     io_cmd_valid, io_cmd_now, req_cmd_ready, hold_c);
         end
      end
      @(posedge clock); #1;
      io_cmd_ready = 1'b1;
      @(negedge clock);
      checks++;
      if (req_cmd_ready !== 4'b0001) begin
         errors++; $display("FAIL bp_resume got %b exp 0001", req_cmd_ready);
      end
      @(posedge clock); #1;
      req_cmd_valid = 4'b0000;
      @(negedge clock);
      checks++;
      if (io_cmd_valid !== 1'b1 || io_cmd_bits_inst_funct !== 7'h22) begin
         errors++; $display("FAIL bp_next got v=%b f=%h exp v=1 f=22", io_cmd_valid, io_cmd_bits_inst_funct);
      end
      repeat (2) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL bp_drain got %0d pending exp 0", exp_q.size());
      end
   endtask

   task automatic test_unexpected;
      @(posedge clock); #1;
      io_resp_valid = 1'b1; io_resp_bits_rd = 5'd7; io_resp_bits_dat = 64'hBAD; req_resp_ready = 4'h0;
      @(negedge clock);
      checks++;
      if (io_resp_ready !== 1'b1 || req_resp_valid !== 4'b0000 || err_unexpected_resp !== 1'b0) begin
         errors++;
         $display("FAIL unexp_sink got rdy=%b v=%b err=%b exp rdy=1 v=0000 err=0",
                  io_resp_ready, req_resp_valid, err_unexpected_resp);
      end
      @(posedge clock); #1;
      io_resp_valid = 1'b0;
      req_resp_ready = 4'hF;
      repeat (3) @(negedge clock);
      checks++;
      if (err_unexpected_resp !== 1'b1) begin
         errors++; $display("FAIL unexp_sticky got %b exp 1", err_unexpected_resp);
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({7'(50 + i), 5'(i), 1'b1, 64'(i), 64'(i)});
         send(2'(i), 7'(50 + i), 5'(25 + i), 1'b1, 64'(i), 64'(i));
      end
      repeat (2) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL mid_issue got %0d pending exp 0", exp_q.size());
      end
      @(posedge clock); #1;
      io_cmd_ready = 1'b0;
      set_req(2'd3, 7'd60, 5'd1, 1'b0, 64'h60, 64'h61);
      req_cmd_valid = 4'b1000;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (io_cmd_valid !== 1'b1) begin
         errors++; $display("FAIL mid_full got %b exp 1", io_cmd_valid);
      end
      @(posedge clock); #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if (io_cmd_valid !== 1'b0 || io_cmd_now !== '0 || req_cmd_ready !== 4'b0000 ||
          err_unexpected_resp !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got v=%b bits=%h rdy=%b err=%b exp all 0",
                  io_cmd_valid, io_cmd_now, req_cmd_ready, err_unexpected_resp);
      end
      exp_q.delete();
      grant_q.delete();
      @(posedge clock); #1;
      reset_n = 1'b1;
      req_cmd_valid = 4'b0000;
      io_cmd_ready = 1'b1;
      @(posedge clock); #1;
      io_resp_valid = 1'b1; io_resp_bits_rd = 5'd1; io_resp_bits_dat = 64'h77;
      @(negedge clock);
      checks++;
      if (io_resp_ready !== 1'b1 || req_resp_valid !== 4'b0000) begin
         errors++; $display("FAIL mid_stale got rdy=%b v=%b exp rdy=1 v=0000", io_resp_ready, req_resp_valid);
      end
      @(posedge clock); #1;
      io_resp_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (err_unexpected_resp !== 1'b1) begin
         errors++; $display("FAIL mid_err got %b exp 1", err_unexpected_resp);
      end
      exp_q.push_back({7'd70, 5'd0, 1'b1, 64'h70, 64'h71});
      send(2'd1, 7'd70, 5'd5, 1'b1, 64'h70, 64'h71);
      repeat (2) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL mid_tag0 got %0d pending exp 0", exp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      req_cmd_valid = 4'h0;
      req_cmd_xd = 4'h0;
      for (int i = 0; i < 4; i++) begin
         f_a[i] = '0; rd_a[i] = '0; rs1_a[i] = '0; rs2_a[i] = '0;
      end
      req_resp_ready = 4'hF;
      io_cmd_ready = 1'b1;
      io_resp_valid = 1'b0;
      io_resp_bits_rd = '0;
      io_resp_bits_dat = '0;
      test_reset;
      test_round_robin;
      test_remap;
      test_tag_exhaust;
      test_backpressure;
      test_unexpected;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
